// File: rtl/int_source_pkg.sv
// Shared types and helpers for the programmable interrupt source.
// Holds the FSM state encoding, the default acknowledge address and the ack decode.
package int_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ASSERT = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_ACK_ADDR = 32'h0000_7F20;

  // A store acknowledges when any byte lane is enabled and the word address matches.
  function automatic logic isAck(input logic [31:0] addr, input logic [3:0] byteen,
                                 input logic [31:0] ackAddr);
    return (|byteen) && (addr[31:2] == ackAddr[31:2]);
  endfunction

endpackage

// File: rtl/int_source_timer.sv
// Loadable down-counter that stops at zero.
// Shared between the trigger delay and the acknowledge timeout.
module int_source_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] loadVal_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Load has priority over counting; the count holds once it reaches zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadVal_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/int_source_gen.sv
// Programmable interrupt source: fires after a cycle delay or on a PC match,
// holds the request until acknowledged or timed out, and can re-fire.
module int_source_gen
  import int_source_pkg::*;
#(
  parameter logic [31:0] ACK_ADDR = DEFAULT_ACK_ADDR,
  parameter int          CNT_W    = 16,
  parameter int          TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             arm,
  input  logic             mode,
  input  logic [CNT_W-1:0] trig_delay,
  input  logic [31:0]      trig_pc,
  input  logic [7:0]       repeat_cnt,
  input  logic [31:0]      macroscopic_pc,
  input  logic [31:0]      m_int_addr,
  input  logic [3:0]       m_int_byteen,
  output logic             interrupt,
  output logic             busy,
  output logic [15:0]      fire_count,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [31:0]      trigPc_q, trigPc_d;
  logic [7:0]       repLeft_q, repLeft_d;
  logic             pcBlock_q, pcBlock_d;
  logic             pcHit_q, pcHit_d;
  logic             interrupt_q, interrupt_d;
  logic [15:0]      fireCount_q, fireCount_d;
  logic             timeoutErr_q, timeoutErr_d;

  logic             tmrLoad, tmrEn, tmrZero;
  logic [CNT_W-1:0] tmrLoadVal;
  logic             ackSeen, pcEq;

  int_source_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (tmrLoad),
    .loadVal_i (tmrLoadVal),
    .en_i      (tmrEn),
    .zero_o    (tmrZero)
  );

  assign ackSeen = isAck(m_int_addr, m_int_byteen, ACK_ADDR);
  assign pcEq    = (macroscopic_pc == trigPc_q);

  // In PC mode a qualified match is registered in pcHit_q first, so the
  // request rises one edge after the match is sampled.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    delay_d      = delay_q;
    trigPc_d     = trigPc_q;
    repLeft_d    = repLeft_q;
    pcBlock_d    = pcBlock_q;
    pcHit_d      = 1'b0;
    interrupt_d  = interrupt_q;
    fireCount_d  = fireCount_q;
    timeoutErr_d = timeoutErr_q;
    tmrLoad      = 1'b0;
    tmrLoadVal   = delay_q;
    tmrEn        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d    = ST_ARMED;
          mode_d     = mode;
          delay_d    = trig_delay;
          trigPc_d   = trig_pc;
          repLeft_d  = repeat_cnt;
          pcBlock_d  = (macroscopic_pc == trig_pc);
          tmrLoad    = 1'b1;
          tmrLoadVal = trig_delay;
        end
      end

      ST_ARMED: begin
        if (!mode_q) begin
          if (tmrZero) begin
            state_d     = ST_ASSERT;
            interrupt_d = 1'b1;
            tmrLoad     = 1'b1;
            tmrLoadVal  = TIMEOUT_LOAD;
          end else begin
            tmrEn = 1'b1;
          end
        end else begin
          if (!pcEq) begin
            pcBlock_d = 1'b0;
          end
          pcHit_d = pcEq && !pcBlock_q;
          if (pcHit_q) begin
            state_d     = ST_ASSERT;
            interrupt_d = 1'b1;
            tmrLoad     = 1'b1;
            tmrLoadVal  = TIMEOUT_LOAD;
          end
        end
      end

      ST_ASSERT: begin
        // An ack in the same cycle as the timeout expiring still counts.
        if (ackSeen) begin
          interrupt_d = 1'b0;
          if (fireCount_q != 16'hFFFF) begin
            fireCount_d = fireCount_q + 16'd1;
          end
          if (repLeft_q != 8'd0) begin
            repLeft_d = repLeft_q - 8'd1;
            state_d   = ST_ARMED;
            if (!mode_q) begin
              tmrLoad    = 1'b1;
              tmrLoadVal = delay_q;
            end else begin
              pcBlock_d = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tmrZero) begin
          interrupt_d  = 1'b0;
          timeoutErr_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          tmrEn = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        interrupt_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= 1'b0;
      delay_q      <= '0;
      trigPc_q     <= '0;
      repLeft_q    <= '0;
      pcBlock_q    <= 1'b0;
      pcHit_q      <= 1'b0;
      interrupt_q  <= 1'b0;
      fireCount_q  <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      delay_q      <= delay_d;
      trigPc_q     <= trigPc_d;
      repLeft_q    <= repLeft_d;
      pcBlock_q    <= pcBlock_d;
      pcHit_q      <= pcHit_d;
      interrupt_q  <= interrupt_d;
      fireCount_q  <= fireCount_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  assign interrupt   = interrupt_q;
  assign busy        = (state_q != ST_IDLE);
  assign fire_count  = fireCount_q;
  assign timeout_err = timeoutErr_q;

endmodule

// File: doc/int_source_gen.md
# int_source_gen

- Programmable interrupt source for the P7 CPU system; it is the device end of the CPU's interrupt interface.
- Drives `interrupt` into `mips` and watches the CPU's interrupt-acknowledge store, reported on `m_int_addr` / `m_int_byteen`.
- Raises a level interrupt after a programmed cycle delay, or when `macroscopic_pc` hits a programmed address.
- Holds the interrupt until the CPU acknowledges it or a timeout expires, and can re-fire a programmed number of times.

## Interface
- `ACK_ADDR`, 32'h0000_7F20: acknowledge word address; compared on bits [31:2].
- `CNT_W`, 16: width of the delay and timeout counters.
- `TIMEOUT`, 1024: cycles in ASSERT without an acknowledge before aborting.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `arm`  in  1  single-cycle start pulse; honoured only in IDLE.
- `mode`  in  1  0 = cycle-delay trigger, 1 = PC-match trigger; sampled on `arm`.
- `trig_delay`  in  CNT_W  delay in cycles; sampled on `arm`.
- `trig_pc`  in  32  PC to match; sampled on `arm`.
- `repeat_cnt`  in  8  extra firings after the first; sampled on `arm`.
- `macroscopic_pc`  in  32  CPU's committed PC.
- `m_int_addr`  in  32  CPU interrupt-store address.
- `m_int_byteen`  in  4  CPU interrupt-store byte enables.
- `interrupt`  out  1  registered interrupt request to the CPU.
- `busy`  out  1  high when not IDLE.
- `fire_count`  out  16  number of acknowledged interrupts since reset; saturates at 16'hFFFF.
- `timeout_err`  out  1  sticky; set on timeout, cleared only by reset.

## Operation
- **Ack condition:** `|m_int_byteen && m_int_addr[31:2] == ACK_ADDR[31:2]`.
- **States:** IDLE, ARMED, ASSERT.
- **IDLE → ARMED on `arm`:**
  - Latch `mode`, `trig_pc`, `repeat_cnt` into `rep_left`.
  - Load the counter with `trig_delay`.
  - Set `pc_block` = (`macroscopic_pc == trig_pc`).
- **ARMED, mode 0:**
  - Counter decrements each cycle.
  - When the counter is 0 (including a load of 0), go to ASSERT.
- **ARMED, mode 1:**
  - `pc_block` clears on any cycle where PC ≠ latched `trig_pc`.
  - A match with `pc_block` = 0 goes to ASSERT.
- **Entry to ASSERT:** counter loaded with TIMEOUT−1; `interrupt` = 1.
- **ASSERT, ack seen:**
  - `fire_count` += 1.
  - If `rep_left` > 0: decrement it, reload the delay (mode 0) or set `pc_block` = 1 (mode 1), go to ARMED.
  - Otherwise go to IDLE.
- **ASSERT, counter reaches 0 with no ack:** set `timeout_err`, go to IDLE; `fire_count` unchanged.
- **Ack and timeout in the same cycle:** the ack wins.
- **Acks outside ASSERT:** ignored.
- **`arm` outside IDLE:** ignored; latched config is unchanged.
- **Width and wrap rules:**
  - `trig_delay` is unsigned.
  - Counters never wrap below 0.
  - `fire_count` saturates.
  - `rep_left` is 8-bit, so up to 256 firings per arm.
- **Config stability:** latched config is frozen for the whole arm session; input changes have no effect until the next IDLE arm.

## Timing
- **Reset (async assert, sync release):** state = IDLE; `interrupt` = 0; `busy` = 0; `fire_count` = 0; `timeout_err` = 0; counters = 0; `pc_block` = 0.
- **Reset mid-ASSERT:** `interrupt` drops immediately, without waiting for a clock edge.
- **Mode 0 latency:** `arm` at edge N with `trig_delay` = D gives `interrupt` high after edge N+D+1. D = 0 gives `interrupt` high after edge N+1.
- **Mode 1 latency:** a PC match sampled at edge M gives `interrupt` high after edge M+1.
- **Deassert:** ack sampled at edge A gives `interrupt` low after edge A.
- **Re-fire (mode 0):** the next assertion follows after edge A+D+1.
- **Timeout:** `interrupt` is high for exactly TIMEOUT cycles when no ack arrives.
- **`busy`:** tracks the registered state.

## Structure
- **Package `int_source_pkg`:**
  - State enum.
  - Default `ACK_ADDR`.
  - Ack-compare function on address bits [31:2].
- **Sub-module `int_source_timer`:**
  - Loadable down-counter, CNT_W wide.
  - Ports: load, load value, enable, zero flag.
  - One instance, shared between the trigger delay and the ack timeout.
- **Top level:** the FSM, `pc_block`, `rep_left` and the output registers.

## Test plan
- **Reset mid-assert:** arm mode 0, D = 3, reach ASSERT, drop `reset_n` mid-cycle → `interrupt` = 0 asynchronously; `busy` = 0; `fire_count` = 0.
- **Single fire with ack:** mode 0, D = 5, `repeat_cnt` = 0; arm at edge 10 → `interrupt` high after edge 16. Store with byteen 4'b1111 to 0x7F20 at edge 20 → low after edge 20; `fire_count` = 1; IDLE.
- **Repeat firing:** mode 0, D = 2, `repeat_cnt` = 2, ack 1 cycle after each assertion → 3 pulses; `fire_count` = 3; then IDLE.
- **Near-miss address:**
  - Ack at 0x7F24 → ignored.
  - Ack at 0x7F22 with byteen 4'b0100 → accepted.
  - Byteen 0 at 0x7F20 → ignored.
- **PC-match trigger:** mode 1, `trig_pc` = 0x3010, `repeat_cnt` = 1.
  - PC already equals 0x3010 at arm → no fire until the PC leaves and returns.
  - After the first ack, a second match fires only after the PC differs.
- **Timeout and arm-while-busy:** TIMEOUT = 8, never ack → `interrupt` high for 8 cycles; `timeout_err` = 1 (sticky); `fire_count` unchanged. An `arm` pulse during ARMED changes nothing.
